// File: rtl/axi_port_router.sv
// ---------------------------------------------------------------------------
// axi_port_router: AXI4 single-slave front end that routes AW/AR by a runtime
// rule table to NoMstPorts master ports, with an internal DECERR error slave.
// Optional: define AXI_DEFAULT_PORT_EN to route unmatched addresses to a port.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module axi_port_router #(
  parameter int NoMstPorts = 4,
  parameter int NoRules    = 4,
  parameter int AddrWidth  = 32,
  parameter int DataWidth  = 32,
  parameter int IdWidth    = 4,
  parameter int MaxTrans   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
`ifdef AXI_DEFAULT_PORT_EN
  input  logic                             en_default_i,
  input  logic [$clog2(NoMstPorts)-1:0]    default_idx_i,
`endif
  input  logic [NoRules*($clog2(NoMstPorts)+2*AddrWidth)-1:0] addr_map_i,
  input  logic                             s_aw_valid,
  output logic                             s_aw_ready,
  input  logic [IdWidth-1:0]               s_aw_id,
  input  logic [AddrWidth-1:0]             s_aw_addr,
  input  logic [7:0]                       s_aw_len,
  input  logic                             s_w_valid,
  output logic                             s_w_ready,
  input  logic [DataWidth-1:0]             s_w_data,
  input  logic                             s_w_last,
  output logic                             s_b_valid,
  input  logic                             s_b_ready,
  output logic [IdWidth-1:0]               s_b_id,
  output logic [1:0]                       s_b_resp,
  input  logic                             s_ar_valid,
  output logic                             s_ar_ready,
  input  logic [IdWidth-1:0]               s_ar_id,
  input  logic [AddrWidth-1:0]             s_ar_addr,
  input  logic [7:0]                       s_ar_len,
  output logic                             s_r_valid,
  input  logic                             s_r_ready,
  output logic [IdWidth-1:0]               s_r_id,
  output logic [DataWidth-1:0]             s_r_data,
  output logic [1:0]                       s_r_resp,
  output logic                             s_r_last,
  output logic [NoMstPorts-1:0]                m_aw_valid,
  input  logic [NoMstPorts-1:0]                m_aw_ready,
  output logic [NoMstPorts-1:0][IdWidth-1:0]   m_aw_id,
  output logic [NoMstPorts-1:0][AddrWidth-1:0] m_aw_addr,
  output logic [NoMstPorts-1:0][7:0]           m_aw_len,
  output logic [NoMstPorts-1:0]                m_w_valid,
  input  logic [NoMstPorts-1:0]                m_w_ready,
  output logic [NoMstPorts-1:0][DataWidth-1:0] m_w_data,
  output logic [NoMstPorts-1:0]                m_w_last,
  input  logic [NoMstPorts-1:0]                m_b_valid,
  output logic [NoMstPorts-1:0]                m_b_ready,
  input  logic [NoMstPorts-1:0][IdWidth-1:0]   m_b_id,
  input  logic [NoMstPorts-1:0][1:0]           m_b_resp,
  output logic [NoMstPorts-1:0]                m_ar_valid,
  input  logic [NoMstPorts-1:0]                m_ar_ready,
  output logic [NoMstPorts-1:0][IdWidth-1:0]   m_ar_id,
  output logic [NoMstPorts-1:0][AddrWidth-1:0] m_ar_addr,
  output logic [NoMstPorts-1:0][7:0]           m_ar_len,
  input  logic [NoMstPorts-1:0]                m_r_valid,
  output logic [NoMstPorts-1:0]                m_r_ready,
  input  logic [NoMstPorts-1:0][IdWidth-1:0]   m_r_id,
  input  logic [NoMstPorts-1:0][DataWidth-1:0] m_r_data,
  input  logic [NoMstPorts-1:0][1:0]           m_r_resp,
  input  logic [NoMstPorts-1:0]                m_r_last
);

  localparam int IW = $clog2(NoMstPorts);
  localparam int TW = $clog2(NoMstPorts + 1);
  localparam int RW = IW + 2 * AddrWidth;
  localparam int CW = $clog2(MaxTrans + 1);
  localparam int PW = $clog2(MaxTrans);
  localparam logic [TW-1:0] ERR_TGT = TW'(NoMstPorts);
  localparam logic [CW-1:0] MAX_CNT = CW'(MaxTrans);

  typedef enum logic [1:0] {EW_IDLE, EW_DATA, EW_RESP} ew_state_e;
  typedef enum logic [0:0] {ER_IDLE, ER_DATA} er_state_e;

  logic [TW-1:0] dflt_tgt, aw_tgt, ar_tgt, wr_tgt, rd_tgt, w_tgt;
  logic [CW-1:0] wr_cnt, rd_cnt, wf_cnt;
  logic [PW-1:0] wf_wr, wf_rd;
  logic [TW-1:0] wf_mem [MaxTrans];
  logic aw_allow, ar_allow, aw_tgt_ready, ar_tgt_ready, w_tgt_ready, w_tgt_vld;
  logic aw_fire, ar_fire, w_pop, b_fire, r_done, wf_full, wr_busy, rd_busy;
  logic b_sel_valid, r_sel_valid;
  logic err_aw_valid, err_aw_ready, err_w_valid, err_w_ready, err_b_valid, err_b_ready;
  logic err_ar_valid, err_ar_ready, err_r_valid, err_r_ready, err_r_last;
  ew_state_e ew_state, ew_next;
  er_state_e er_state, er_next;
  logic [IdWidth-1:0] ew_id, er_id;
  logic [7:0] er_len, er_beat;

  // Highest-index matching rule wins because later rules overwrite earlier ones.
  function automatic logic [TW-1:0] decode(input logic [AddrWidth-1:0] addr,
                                           input logic [NoRules*RW-1:0] map,
                                           input logic [TW-1:0] dflt);
    logic [TW-1:0] tgt;
    logic [IW-1:0] idx;
    logic [AddrWidth-1:0] lo, hi;
    tgt = dflt;
    for (int r = 0; r < NoRules; r++) begin
      {idx, lo, hi} = map[r*RW +: RW];
      if (addr >= lo && addr < hi) tgt = TW'(idx);
    end
    return tgt;
  endfunction

`ifdef AXI_DEFAULT_PORT_EN
  assign dflt_tgt = en_default_i ? TW'(default_idx_i) : ERR_TGT;

  logic ax_pending;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ax_pending <= 1'b0;
    else       ax_pending <= (s_aw_valid & ~s_aw_ready) | (s_ar_valid & ~s_ar_ready);
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
                   ax_pending |-> $stable({en_default_i, default_idx_i}))
    else $fatal(1, "default route changed while an address request was pending");
`else
  assign dflt_tgt = ERR_TGT;
`endif

  assign wr_busy = (wr_cnt != '0);
  assign rd_busy = (rd_cnt != '0);
  assign wf_full = (wf_cnt == MAX_CNT);

  always_comb begin
    aw_tgt = decode(s_aw_addr, addr_map_i, dflt_tgt);
    aw_allow = ~rst_i & ~wf_full &
               (~wr_busy | ((aw_tgt == wr_tgt) & (wr_cnt != MAX_CNT)));
    aw_tgt_ready = (aw_tgt == ERR_TGT) & err_aw_ready;
    for (int t = 0; t < NoMstPorts; t++) begin
      m_aw_valid[t] = s_aw_valid & aw_allow & (aw_tgt == TW'(t));
      if (aw_tgt == TW'(t)) aw_tgt_ready = m_aw_ready[t];
    end
    err_aw_valid = s_aw_valid & aw_allow & (aw_tgt == ERR_TGT);
    s_aw_ready = aw_allow & aw_tgt_ready;
  end

  always_comb begin
    ar_tgt = decode(s_ar_addr, addr_map_i, dflt_tgt);
    ar_allow = ~rst_i & (~rd_busy | ((ar_tgt == rd_tgt) & (rd_cnt != MAX_CNT)));
    ar_tgt_ready = (ar_tgt == ERR_TGT) & err_ar_ready;
    for (int t = 0; t < NoMstPorts; t++) begin
      m_ar_valid[t] = s_ar_valid & ar_allow & (ar_tgt == TW'(t));
      if (ar_tgt == TW'(t)) ar_tgt_ready = m_ar_ready[t];
    end
    err_ar_valid = s_ar_valid & ar_allow & (ar_tgt == ERR_TGT);
    s_ar_ready = ar_allow & ar_tgt_ready;
  end

  assign aw_fire = s_aw_valid & s_aw_ready;
  assign ar_fire = s_ar_valid & s_ar_ready;

  // An empty FIFO bypasses the target of an AW accepted in the same cycle.
  always_comb begin
    w_tgt_vld = (wf_cnt != '0) | aw_fire;
    w_tgt = (wf_cnt != '0) ? wf_mem[wf_rd] : aw_tgt;
    w_tgt_ready = (w_tgt == ERR_TGT) & err_w_ready;
    for (int t = 0; t < NoMstPorts; t++) begin
      m_w_valid[t] = s_w_valid & w_tgt_vld & (w_tgt == TW'(t));
      if (w_tgt == TW'(t)) w_tgt_ready = m_w_ready[t];
    end
    err_w_valid = s_w_valid & w_tgt_vld & (w_tgt == ERR_TGT);
    s_w_ready = ~rst_i & w_tgt_vld & w_tgt_ready;
  end

  assign w_pop = s_w_valid & s_w_ready & s_w_last;

  always_comb begin
    b_sel_valid = (wr_tgt == ERR_TGT) & err_b_valid;
    s_b_id = ew_id;
    s_b_resp = 2'b11;
    for (int t = 0; t < NoMstPorts; t++) begin
      m_b_ready[t] = s_b_ready & wr_busy & (wr_tgt == TW'(t));
      if (wr_tgt == TW'(t)) begin
        b_sel_valid = m_b_valid[t];
        s_b_id = m_b_id[t];
        s_b_resp = m_b_resp[t];
      end
    end
    err_b_ready = s_b_ready & wr_busy & (wr_tgt == ERR_TGT);
    s_b_valid = wr_busy & b_sel_valid;
  end

  always_comb begin
    r_sel_valid = (rd_tgt == ERR_TGT) & err_r_valid;
    s_r_id = er_id;
    s_r_data = '0;
    s_r_resp = 2'b11;
    s_r_last = err_r_last;
    for (int t = 0; t < NoMstPorts; t++) begin
      m_r_ready[t] = s_r_ready & rd_busy & (rd_tgt == TW'(t));
      if (rd_tgt == TW'(t)) begin
        r_sel_valid = m_r_valid[t];
        s_r_id = m_r_id[t];
        s_r_data = m_r_data[t];
        s_r_resp = m_r_resp[t];
        s_r_last = m_r_last[t];
      end
    end
    err_r_ready = s_r_ready & rd_busy & (rd_tgt == ERR_TGT);
    s_r_valid = rd_busy & r_sel_valid;
  end

  assign b_fire = s_b_valid & s_b_ready;
  assign r_done = s_r_valid & s_r_ready & s_r_last;

  for (genvar t = 0; t < NoMstPorts; t++) begin : g_bcast
    assign m_aw_id[t]   = s_aw_id;
    assign m_aw_addr[t] = s_aw_addr;
    assign m_aw_len[t]  = s_aw_len;
    assign m_w_data[t]  = s_w_data;
    assign m_w_last[t]  = s_w_last;
    assign m_ar_id[t]   = s_ar_id;
    assign m_ar_addr[t] = s_ar_addr;
    assign m_ar_len[t]  = s_ar_len;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_tgt <= '0;
      rd_tgt <= '0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      wf_cnt <= '0;
      wf_wr  <= '0;
      wf_rd  <= '0;
    end else begin
      if (aw_fire) wr_tgt <= aw_tgt;
      if (ar_fire) rd_tgt <= ar_tgt;
      if (aw_fire != b_fire) wr_cnt <= aw_fire ? wr_cnt + CW'(1) : wr_cnt - CW'(1);
      if (ar_fire != r_done) rd_cnt <= ar_fire ? rd_cnt + CW'(1) : rd_cnt - CW'(1);
      if (aw_fire) wf_wr <= wf_wr + PW'(1);
      if (w_pop)   wf_rd <= wf_rd + PW'(1);
      if (aw_fire != w_pop) wf_cnt <= aw_fire ? wf_cnt + CW'(1) : wf_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_fire) wf_mem[wf_wr] <= aw_tgt;
  end

  assign err_aw_ready = (ew_state == EW_IDLE);
  assign err_w_ready  = (ew_state == EW_DATA);
  assign err_b_valid  = (ew_state == EW_RESP);
  assign err_ar_ready = (er_state == ER_IDLE);
  assign err_r_valid  = (er_state == ER_DATA);
  assign err_r_last   = (er_beat == er_len);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ew_state <= EW_IDLE;
      er_state <= ER_IDLE;
      ew_id    <= '0;
      er_id    <= '0;
      er_len   <= '0;
      er_beat  <= '0;
    end else begin
      ew_state <= ew_next;
      er_state <= er_next;
      if (err_aw_valid && err_aw_ready) ew_id <= s_aw_id;
      if (err_ar_valid && err_ar_ready) begin
        er_id   <= s_ar_id;
        er_len  <= s_ar_len;
        er_beat <= '0;
      end else if (err_r_valid && err_r_ready) begin
        er_beat <= er_beat + 8'd1;
      end
    end
  end

  always_comb begin
    ew_next = ew_state;
    er_next = er_state;
    case (ew_state)
      EW_IDLE: if (err_aw_valid) ew_next = EW_DATA;
      EW_DATA: if (err_w_valid && s_w_last) ew_next = EW_RESP;
      EW_RESP: if (err_b_ready) ew_next = EW_IDLE;
      default: ew_next = EW_IDLE;
    endcase
    case (er_state)
      ER_IDLE: if (err_ar_valid) er_next = ER_DATA;
      ER_DATA: if (err_r_ready && err_r_last) er_next = ER_IDLE;
      default: er_next = ER_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_port_router.sv
// ---------------------------------------------------------------------------
// tb_axi_port_router: directed self-checking bench for axi_port_router.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi_port_router;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IDW = 4;
  localparam int MT  = 8;
  localparam int NR  = 4;
  localparam int RW  = 2 + 2 * AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR*RW-1:0] addr_map;
  logic s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_w_last, s_b_valid, s_b_ready;
  logic s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_r_last;
  logic [IDW-1:0] s_aw_id, s_b_id, s_ar_id, s_r_id;
  logic [AW-1:0] s_aw_addr, s_ar_addr;
  logic [7:0] s_aw_len, s_ar_len;
  logic [DW-1:0] s_w_data, s_r_data;
  logic [1:0] s_b_resp, s_r_resp;
  logic [N-1:0] m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_w_last, m_b_valid, m_b_ready;
  logic [N-1:0] m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last;
  logic [N-1:0][IDW-1:0] m_aw_id, m_b_id, m_ar_id, m_r_id;
  logic [N-1:0][AW-1:0] m_aw_addr, m_ar_addr;
  logic [N-1:0][7:0] m_aw_len, m_ar_len;
  logic [N-1:0][DW-1:0] m_w_data, m_r_data;
  logic [N-1:0][1:0] m_b_resp, m_r_resp;

  axi_port_router #(
    .NoMstPorts(N), .NoRules(NR), .AddrWidth(AW), .DataWidth(DW),
    .IdWidth(IDW), .MaxTrans(MT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .addr_map_i(addr_map),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id),
    .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id),
    .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    addr_map = {2'd3, 32'h3000, 32'h4000, 2'd2, 32'h1800, 32'h2000,
                2'd1, 32'h1000, 32'h2000, 2'd0, 32'h0000, 32'h1000};
    s_aw_valid = 1'b1; s_aw_id = '0; s_aw_addr = 32'h0100; s_aw_len = '0;
    s_w_valid = 1'b1; s_w_data = '0; s_w_last = 1'b0; s_b_ready = 1'b0;
    s_ar_valid = 1'b1; s_ar_id = '0; s_ar_addr = 32'h0100; s_ar_len = '0;
    s_r_ready = 1'b1;
    m_aw_ready = '1; m_w_ready = '1; m_ar_ready = '1;
    m_b_valid = '0; m_b_id = '0; m_b_resp = '0;
    m_r_valid = '0; m_r_id = '0; m_r_data = '0; m_r_resp = '0; m_r_last = '0;

    // Reset: no ready or valid escapes while rst is high.
    #2;
    check("rst_aw_ready", s_aw_ready, 0);
    check("rst_ar_ready", s_ar_ready, 0);
    check("rst_w_ready", s_w_ready, 0);
    check("rst_m_aw_valid", m_aw_valid, 0);
    check("rst_m_ar_valid", m_ar_valid, 0);
    step();
    rst = 1'b0; s_aw_valid = 1'b0; s_ar_valid = 1'b0; s_w_valid = 1'b0;
    step();

    // Address decode on AR (combinational, no edge taken).
    s_ar_valid = 1'b1; s_ar_addr = 32'h1900; #1;
    check("dec_1900", m_ar_valid, 4'b0100);
    s_ar_addr = 32'h0FFF; #1;
    check("dec_0fff", m_ar_valid, 4'b0001);
    s_ar_addr = 32'h2000; #1;
    check("dec_2000_mvalid", m_ar_valid, 4'b0000);
    check("dec_2000_ready", s_ar_ready, 1);
    s_ar_valid = 1'b0;

    // W with no outstanding AW is held off.
    s_w_valid = 1'b1; #1;
    check("w_empty_ready", s_w_ready, 0);
    s_w_valid = 1'b0;
    step();

    // Write to unmapped address -> error slave DECERR.
    s_aw_valid = 1'b1; s_aw_addr = 32'h5000; s_aw_id = 4'd3; s_aw_len = 8'd3; #1;
    check("err_aw_ready", s_aw_ready, 1);
    check("err_aw_mvalid", m_aw_valid, 0);
    step();
    s_aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_w_valid = 1'b1; s_w_data = DW'(i); s_w_last = (i == 3); #1;
      check("err_w_ready", s_w_ready, 1);
      check("err_w_mvalid", m_w_valid, 0);
      step();
    end
    s_w_valid = 1'b0; s_w_last = 1'b0; #1;
    check("err_b_valid", s_b_valid, 1);
    check("err_b_id", s_b_id, 3);
    check("err_b_resp", s_b_resp, 2'b11);
    s_b_ready = 1'b1;
    step();
    check("err_b_done", s_b_valid, 0);

    // Read from unmapped address: 3 beats, stall mid-burst.
    s_ar_valid = 1'b1; s_ar_addr = 32'h9000; s_ar_id = 4'd5; s_ar_len = 8'd2; #1;
    check("err_ar_ready", s_ar_ready, 1);
    step();
    s_ar_valid = 1'b0; #1;
    check("err_r0_valid", s_r_valid, 1);
    check("err_r0_id", s_r_id, 5);
    check("err_r0_resp", s_r_resp, 2'b11);
    check("err_r0_data", s_r_data, 0);
    check("err_r0_last", s_r_last, 0);
    step();
    s_r_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("err_r1_hold_valid", s_r_valid, 1);
      check("err_r1_hold_last", s_r_last, 0);
      step();
    end
    s_r_ready = 1'b1; #1;
    check("err_r1_last", s_r_last, 0);
    step();
    check("err_r2_valid", s_r_valid, 1);
    check("err_r2_last", s_r_last, 1);
    step();
    check("err_r_done", s_r_valid, 0);

    // Target switch on reads stalls until the previous target drains.
    s_ar_valid = 1'b1; s_ar_addr = 32'h0100; s_ar_id = 4'd2; s_ar_len = 8'd0;
    step();
    s_ar_addr = 32'h1000; s_ar_id = 4'd4; #1;
    check("sw_stall_ready", s_ar_ready, 0);
    check("sw_stall_mvalid", m_ar_valid, 0);
    step();
    m_r_valid = 4'b0001; m_r_last = 4'b0001; m_r_id[0] = 4'd2; m_r_data[0] = 32'hABCD; #1;
    check("sw_r_valid", s_r_valid, 1);
    check("sw_r_data", s_r_data, 32'hABCD);
    check("sw_m_r_ready", m_r_ready, 4'b0001);
    check("sw_still_stall", s_ar_ready, 0);
    step();
    m_r_valid = '0; m_r_last = '0; #1;
    check("sw_fwd_ready", s_ar_ready, 1);
    check("sw_fwd_mvalid", m_ar_valid, 4'b0010);
    step();
    s_ar_valid = 1'b0;
    m_r_valid = 4'b0010; m_r_last = 4'b0010;
    step();
    m_r_valid = '0; m_r_last = '0;

    // MaxTrans writes to port 1, each with a same-cycle W beat.
    for (int i = 0; i < MT; i++) begin
      s_aw_valid = 1'b1; s_aw_addr = 32'h1000; s_aw_id = 4'd1; s_aw_len = 8'd0;
      s_w_valid = 1'b1; s_w_last = 1'b1; #1;
      check("mt_aw_ready", s_aw_ready, 1);
      check("mt_w_mvalid", m_w_valid, 4'b0010);
      step();
    end
    s_w_valid = 1'b0; s_w_last = 1'b0; #1;
    check("mt_9th_stall", s_aw_ready, 0);
    check("mt_9th_mvalid", m_aw_valid, 0);
    step();
    m_b_valid = 4'b0010; m_b_id[1] = 4'd1; #1;
    check("mt_b_valid", s_b_valid, 1);
    check("mt_b_id", s_b_id, 1);
    check("mt_m_b_ready", m_b_ready, 4'b0010);
    check("mt_stall_during_b", s_aw_ready, 0);
    step();
    m_b_valid = '0; #1;
    check("mt_9th_ready", s_aw_ready, 1);
    step();
    s_aw_valid = 1'b0;
    s_w_valid = 1'b1; s_w_last = 1'b1; #1;
    check("mt_9th_w", m_w_valid, 4'b0010);
    step();
    s_w_valid = 1'b0; s_w_last = 1'b0;
    m_b_valid = 4'b0010;
    for (int i = 0; i < MT; i++) step();
    m_b_valid = '0; #1;
    check("mt_drained_b", s_b_valid, 0);

    // Asynchronous reset in the middle of an error read burst.
    s_ar_valid = 1'b1; s_ar_addr = 32'h9000; s_ar_id = 4'd6; s_ar_len = 8'd3;
    step();
    s_ar_valid = 1'b0; s_r_ready = 1'b0; #1;
    check("mr_r_valid", s_r_valid, 1);
    s_ar_valid = 1'b1; s_ar_addr = 32'h1900; s_ar_id = 4'd7; s_ar_len = 8'd0;
    rst = 1'b1; #1;
    check("mr_rst_r_valid", s_r_valid, 0);
    check("mr_rst_ar_ready", s_ar_ready, 0);
    check("mr_rst_mvalid", m_ar_valid, 0);
    step();
    rst = 1'b0; s_r_ready = 1'b1; #1;
    check("mr_post_mvalid", m_ar_valid, 4'b0100);
    check("mr_post_ready", s_ar_ready, 1);
    step();
    s_ar_valid = 1'b0;
    m_r_valid = 4'b0100; m_r_last = 4'b0100; m_r_id[2] = 4'd7; #1;
    check("mr_post_r_id", s_r_id, 7);
    step();
    m_r_valid = '0; m_r_last = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
